// File: rtl/s_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | s_mem_arbiter: round-robin arbiter with lock and watchdog for S-memory |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module s_mem_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stop,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        wren,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_wren,
  output logic                      mem_rden,
  input  logic [DATA_W-1:0]         mem_q,
  output logic [2:0]                owner,
  output logic                      locked,
  output logic                      lock_err
);

  localparam int c_CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [0:0] {
    ST_FREE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t               r_state;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_owner;
  logic [c_CNT_W-1:0]   r_lock_cnt;
  logic                 r_lock_err;
  logic [NUM_REQ-1:0]   r_rvalid;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [2:0]           w_sel;
  logic                 w_found;
  logic                 w_lk;
  logic                 w_wr;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_data;

  // Grant selection; the search from rr_ptr is split into two passes to wrap.
  always_comb begin
    w_gnt   = '0;
    w_sel   = 3'd0;
    w_found = 1'b0;
    if (reset_n && !stop) begin
      if (r_state == ST_OWNED) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (req[j] && (3'(j) == r_owner)) begin
            w_found  = 1'b1;
            w_sel    = 3'(j);
            w_gnt[j] = 1'b1;
          end
        end
      end else begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!w_found && req[j] && (3'(j) >= r_rr_ptr)) begin
            w_found  = 1'b1;
            w_sel    = 3'(j);
            w_gnt[j] = 1'b1;
          end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!w_found && req[j] && (3'(j) < r_rr_ptr)) begin
            w_found  = 1'b1;
            w_sel    = 3'(j);
            w_gnt[j] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_lk   = 1'b0;
    w_wr   = 1'b0;
    w_addr = '0;
    w_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt[j]) begin
        w_lk   = lock[j];
        w_wr   = wren[j];
        w_addr = addr[j*ADDR_W +: ADDR_W];
        w_data = wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_FREE;
      r_rr_ptr   <= 3'd0;
      r_owner    <= 3'd0;
      r_lock_cnt <= '0;
      r_lock_err <= 1'b0;
      r_rvalid   <= '0;
    end else begin
      r_rvalid <= w_gnt & ~wren;
      if (!stop) begin
        if (w_found)
          r_rr_ptr <= (w_sel == 3'(NUM_REQ - 1)) ? 3'd0 : w_sel + 3'd1;
        case (r_state)
          ST_FREE: begin
            if (w_found && w_lk) begin
              r_state    <= ST_OWNED;
              r_owner    <= w_sel;
              r_lock_cnt <= '0;
            end
          end
          ST_OWNED: begin
            // A voluntary release takes precedence over the watchdog.
            if (!w_found || !w_lk) begin
              r_state    <= ST_FREE;
              r_owner    <= 3'd0;
              r_lock_cnt <= '0;
            end else if (r_lock_cnt == c_CNT_W'(MAX_LOCK - 1)) begin
              r_state    <= ST_FREE;
              r_owner    <= 3'd0;
              r_lock_cnt <= '0;
              r_lock_err <= 1'b1;
            end else begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end
          default: r_state <= ST_FREE;
        endcase
      end
    end
  end

  assign gnt         = w_gnt;
  assign rvalid      = r_rvalid;
  assign rdata       = mem_q;
  assign mem_address = w_addr;
  assign mem_data    = w_data;
  assign mem_wren    = w_found & w_wr;
  assign mem_rden    = w_found & ~w_wr;
  assign owner       = r_owner;
  assign locked      = (r_state == ST_OWNED);
  assign lock_err    = r_lock_err;

endmodule
`default_nettype wire

// File: tb/tb_s_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_s_mem_arbiter: self-checking bench for s_mem_arbiter                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_s_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            stop = 1'b0;
  logic [N-1:0]    req = '0, lock = '0, wren = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_data, mem_q;
  logic [AW-1:0]   mem_address;
  logic            mem_wren, mem_rden, locked, lock_err;
  logic [2:0]      owner;

  s_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n), .stop(stop), .req(req), .lock(lock),
    .wren(wren), .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q),
    .owner(owner), .locked(locked), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  // S-memory attached to the DUT, initialised to S[i] = i
  logic [7:0] smem [256];
  always @(posedge clk) begin
    if (mem_wren) smem[mem_address] <= mem_data;
    if (mem_rden) mem_q <= smem[mem_address];
  end

  // requester stimulus
  bit         t_req [N], t_lock [N], t_wr [N];
  logic [7:0] t_addr [N], t_wd [N];

  // reference model
  int         m_ptr, m_owner, m_cnt, m_g;
  bit         m_locked, m_err;
  logic [N-1:0] m_rv;
  logic [7:0] m_rd;
  logic [7:0] mmem [256];

  // values seen by the compare step this cycle
  logic [N-1:0] s_gnt, s_rv;
  logic [7:0]   s_rdata;
  logic         s_locked, s_err;
  logic [2:0]   s_owner;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_r(input int i, input bit rq, input bit lk, input bit wr,
                       input logic [7:0] a, input logic [7:0] d);
    t_req[i] = rq; t_lock[i] = lk; t_wr[i] = wr; t_addr[i] = a; t_wd[i] = d;
  endtask

  task automatic new_tx(input int i);
    set_r(i, $urandom_range(0, 99) < 45, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0, 8'($urandom_range(0, 31)), 8'($urandom));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]  = t_req[i];
      lock[i] = t_lock[i];
      wren[i] = t_wr[i];
      addr[i*AW +: AW]  = t_addr[i];
      wdata[i*DW +: DW] = t_wd[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; m_err = 0; m_rv = '0; m_g = -1;
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance model.
  task automatic step();
    int g, idx;
    logic [N-1:0] eg;
    logic [7:0] ea, ed;
    drive();
    @(negedge clk);
    g = -1;
    if (!stop) begin
      if (m_locked) begin
        if (t_req[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && t_req[idx]) g = idx;
        end
      end
    end
    eg = '0; ea = '0; ed = '0;
    if (g >= 0) begin
      eg[g] = 1'b1; ea = t_addr[g]; ed = t_wd[g];
    end
    chk("gnt", gnt, eg);
    chk("mem_address", mem_address, ea);
    chk("mem_data", mem_data, ed);
    chk("mem_wren", mem_wren, (g >= 0) && t_wr[g]);
    chk("mem_rden", mem_rden, (g >= 0) && !t_wr[g]);
    chk("rvalid", rvalid, m_rv);
    if (m_rv != '0) chk("rdata", rdata, m_rd);
    chk("locked", locked, m_locked);
    chk("owner", owner, m_owner);
    chk("lock_err", lock_err, m_err);
    s_gnt = gnt; s_rv = rvalid; s_rdata = rdata;
    s_locked = locked; s_err = lock_err; s_owner = owner;

    m_rv = '0;
    if (g >= 0) begin
      if (t_wr[g]) mmem[t_addr[g]] = t_wd[g];
      else begin
        m_rv[g] = 1'b1;
        m_rd = mmem[t_addr[g]];
      end
      m_ptr = (g + 1) % N;
      if (!m_locked) begin
        if (t_lock[g]) begin m_locked = 1; m_owner = g; m_cnt = 0; end
      end else if (!t_lock[g]) begin
        m_locked = 0; m_owner = 0;
      end else begin
        m_cnt++;
        if (m_cnt == ML) begin m_locked = 0; m_owner = 0; m_err = 1; end
      end
    end else if (!stop && m_locked) begin
      m_locked = 0; m_owner = 0;
    end
    m_g = g;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    drive();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_strobes", {mem_wren, mem_rden}, 0);
    chk("rst_addr_data", {mem_address, mem_data}, 0);
    chk("rst_lock", {locked, owner, lock_err}, 0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  localparam logic [N-1:0] c_RR [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    for (int a = 0; a < 256; a++) begin
      smem[a] = 8'(a);
      mmem[a] = 8'(a);
    end
    for (int i = 0; i < N; i++) set_r(i, 1, 0, 0, 8'(i), 8'h00);
    model_reset();
    #1;
    do_reset();

    // round robin with everyone requesting
    for (int c = 0; c < 6; c++) begin
      step();
      chk("rr_seq", s_gnt, c_RR[c]);
    end

    // tagged reads
    for (int i = 0; i < N; i++) set_r(i, 0, 0, 0, 8'h00, 8'h00);
    set_r(0, 1, 0, 0, 8'h05, 8'h00);
    step();
    chk("tag_gnt0", s_gnt, 3'b001);
    set_r(0, 0, 0, 0, 8'h00, 8'h00);
    set_r(2, 1, 0, 0, 8'h10, 8'h00);
    step();
    chk("tag_gnt2", s_gnt, 3'b100);
    chk("tag_rv0", s_rv, 3'b001);
    chk("tag_rdata0", s_rdata, 8'h05);
    set_r(2, 0, 0, 0, 8'h00, 8'h00);
    step();
    chk("tag_rv2", s_rv, 3'b100);
    chk("tag_rdata2", s_rdata, 8'h10);

    // move the pointer to 1, then a locked swap of S[0x20] and S[0x30]
    set_r(0, 1, 0, 0, 8'h00, 8'h00);
    step();
    set_r(0, 1, 0, 0, 8'h40, 8'h00);
    set_r(2, 1, 0, 0, 8'h41, 8'h00);
    set_r(1, 1, 1, 0, 8'h20, 8'h00);
    step();
    chk("swap_gnt_c1", s_gnt, 3'b010);
    set_r(1, 1, 1, 0, 8'h30, 8'h00);
    step();
    chk("swap_gnt_c2", s_gnt, 3'b010);
    chk("swap_own_c2", {s_locked, s_owner}, {1'b1, 3'd1});
    chk("swap_rd_c2", s_rdata, 8'h20);
    set_r(1, 1, 1, 1, 8'h20, 8'h30);
    step();
    chk("swap_gnt_c3", s_gnt, 3'b010);
    chk("swap_rd_c3", s_rdata, 8'h30);
    set_r(1, 1, 0, 1, 8'h30, 8'h20);
    step();
    chk("swap_gnt_c4", s_gnt, 3'b010);
    chk("swap_own_c4", {s_locked, s_owner}, {1'b1, 3'd1});
    set_r(1, 0, 0, 0, 8'h00, 8'h00);
    step();
    chk("swap_after", s_gnt, 3'b100);
    chk("swap_unlocked", s_locked, 1'b0);
    set_r(2, 0, 0, 0, 8'h00, 8'h00);
    step();
    chk("pending_req0", s_gnt, 3'b001);
    set_r(0, 0, 0, 0, 8'h00, 8'h00);
    set_r(1, 1, 0, 0, 8'h20, 8'h00);
    step();
    set_r(1, 1, 0, 0, 8'h21, 8'h00);
    set_r(0, 1, 1, 0, 8'h50, 8'h00);
    step();
    chk("swap_result", s_rdata, 8'h30);
    chk("wd_first_gnt", s_gnt, 3'b001);

    // watchdog: owner 0 never releases
    for (int c = 0; c < ML; c++) begin
      step();
      chk("wd_hold_gnt", s_gnt, 3'b001);
      chk("wd_hold_locked", s_locked, 1'b1);
    end
    step();
    chk("wd_release_gnt", s_gnt, 3'b010);
    chk("wd_err", s_err, 1'b1);
    chk("wd_unlocked", s_locked, 1'b0);

    // stop freezes grants and the pointer
    set_r(0, 1, 0, 0, 8'h01, 8'h00);
    set_r(1, 1, 0, 0, 8'h02, 8'h00);
    stop = 1'b1;
    step();
    chk("stop_gnt", s_gnt, 3'b000);
    chk("stop_inflight_rv", s_rv, 3'b010);
    step();
    chk("stop_gnt2", s_gnt, 3'b000);
    stop = 1'b0;
    step();
    chk("stop_resume", s_gnt, 3'b001);
    chk("stop_err_kept", s_err, 1'b1);

    // reset in the middle of a lock and a pending read
    set_r(0, 1, 1, 0, 8'h03, 8'h00);
    step();
    do_reset();

    // release at the watchdog limit wins over the watchdog
    for (int i = 0; i < N; i++) set_r(i, 0, 0, 0, 8'h00, 8'h00);
    set_r(0, 1, 1, 0, 8'h07, 8'h00);
    step();
    chk("rel_first_gnt", s_gnt, 3'b001);
    for (int c = 0; c < ML - 1; c++) step();
    set_r(0, 1, 0, 0, 8'h08, 8'h00);
    step();
    chk("rel_last_gnt", s_gnt, 3'b001);
    set_r(0, 0, 0, 0, 8'h00, 8'h00);
    step();
    chk("rel_no_err", s_err, 1'b0);
    chk("rel_unlocked", s_locked, 1'b0);

    // randomized traffic
    for (int i = 0; i < N; i++) new_tx(i);
    for (int c = 0; c < 800; c++) begin
      stop = ($urandom_range(0, 9) == 0);
      step();
      for (int i = 0; i < N; i++)
        if (!t_req[i] || m_g == i) new_tx(i);
      if (c == 400) do_reset();
    end
    stop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
